// File: rtl/alu_issue_reg_pkg.sv
// Shared definitions for the ID/EX issue register in front of alu_hier:
// compact opcode values, alu_hier Oper encodings and the decoded control bundle.
package alu_issue_reg_pkg;

    localparam int OPERAND_WIDTH  = 16;
    localparam int NUM_OPERATIONS = 3;
    localparam int REG_ADDR_W     = 3;
    localparam int ALU_OP_W       = 4;

    // Compact opcodes arriving from decode.
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ANDN = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_ROL  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_ROR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_ADDU = 4'd9;

    // alu_hier operation select encodings.
    localparam logic [NUM_OPERATIONS-1:0] OPER_ROL = 3'b000;
    localparam logic [NUM_OPERATIONS-1:0] OPER_SLL = 3'b001;
    localparam logic [NUM_OPERATIONS-1:0] OPER_ROR = 3'b010;
    localparam logic [NUM_OPERATIONS-1:0] OPER_SRL = 3'b011;
    localparam logic [NUM_OPERATIONS-1:0] OPER_ADD = 3'b100;
    localparam logic [NUM_OPERATIONS-1:0] OPER_OR  = 3'b101;
    localparam logic [NUM_OPERATIONS-1:0] OPER_XOR = 3'b110;
    localparam logic [NUM_OPERATIONS-1:0] OPER_AND = 3'b111;

    // Decoded control set handed to alu_hier, plus the illegal-opcode flag.
    typedef struct packed {
        logic [NUM_OPERATIONS-1:0] oper;
        logic                      inv_a;
        logic                      inv_b;
        logic                      cin;
        logic                      sign;
        logic                      illegal;
    } alu_ctrl_t;

    // Bundle constructor keeps the decode table readable as one row per opcode.
    function automatic alu_ctrl_t make_ctrl(
        input logic [NUM_OPERATIONS-1:0] oper,
        input logic                      inv_a,
        input logic                      inv_b,
        input logic                      cin,
        input logic                      sign,
        input logic                      illegal
    );
        alu_ctrl_t c;
        c.oper    = oper;
        c.inv_a   = inv_a;
        c.inv_b   = inv_b;
        c.cin     = cin;
        c.sign    = sign;
        c.illegal = illegal;
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_reg_ctrl_dec.sv
// Purely combinational decode of the compact ALU opcode into the alu_hier
// control set. Unknown opcodes (10..15) decode as signed ADD and raise illegal.
module alu_issue_reg_ctrl_dec
    import alu_issue_reg_pkg::*;
(
    input  logic [ALU_OP_W-1:0]       alu_op,
    output logic [NUM_OPERATIONS-1:0] oper,
    output logic                      inv_a,
    output logic                      inv_b,
    output logic                      cin,
    output logic                      sign,
    output logic                      illegal
);

    alu_ctrl_t ctrl_s;

    // Opcode table: one row per compact opcode, illegal codes fall back to ADD.
    always_comb begin
        ctrl_s = make_ctrl(OPER_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        case (alu_op)
            ALU_ADD:  ctrl_s = make_ctrl(OPER_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            // B - A computed as ~A + B + 1
            ALU_SUB:  ctrl_s = make_ctrl(OPER_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            ALU_XOR:  ctrl_s = make_ctrl(OPER_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            // A & ~B via the AND unit with B inverted
            ALU_ANDN: ctrl_s = make_ctrl(OPER_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            ALU_ROL:  ctrl_s = make_ctrl(OPER_ROL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ALU_SLL:  ctrl_s = make_ctrl(OPER_SLL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ALU_ROR:  ctrl_s = make_ctrl(OPER_ROR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ALU_SRL:  ctrl_s = make_ctrl(OPER_SRL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ALU_OR:   ctrl_s = make_ctrl(OPER_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            ALU_ADDU: ctrl_s = make_ctrl(OPER_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default:  ctrl_s = make_ctrl(OPER_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        endcase
    end

    assign oper    = ctrl_s.oper;
    assign inv_a   = ctrl_s.inv_a;
    assign inv_b   = ctrl_s.inv_b;
    assign cin     = ctrl_s.cin;
    assign sign    = ctrl_s.sign;
    assign illegal = ctrl_s.illegal;

endmodule

// File: rtl/alu_issue_reg.sv
// ID/EX issue register feeding alu_hier. Decodes the compact opcode, selects
// operand B from register or immediate, and registers everything with
// priority rst > flush > stall > load. Bubbles clear every output to zero.
module alu_issue_reg
    import alu_issue_reg_pkg::*;
#(
    parameter int OPERAND_WIDTH  = alu_issue_reg_pkg::OPERAND_WIDTH,
    parameter int NUM_OPERATIONS = alu_issue_reg_pkg::NUM_OPERATIONS,
    parameter int REG_ADDR_W     = alu_issue_reg_pkg::REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [3:0]                alu_op,
    input  logic [OPERAND_WIDTH-1:0]  rf_a,
    input  logic [OPERAND_WIDTH-1:0]  rf_b,
    input  logic [OPERAND_WIDTH-1:0]  imm,
    input  logic                      use_imm,
    input  logic [REG_ADDR_W-1:0]     dest_in,
    input  logic                      wr_en_in,
    output logic                      out_valid,
    output logic [OPERAND_WIDTH-1:0]  InA,
    output logic [OPERAND_WIDTH-1:0]  InB,
    output logic [NUM_OPERATIONS-1:0] Oper,
    output logic                      invA,
    output logic                      invB,
    output logic                      Cin,
    output logic                      sign,
    output logic [REG_ADDR_W-1:0]     dest_out,
    output logic                      wr_en_out,
    output logic                      illegal_op
);

    // Decoder outputs
    logic [2:0]                dec_oper_s;
    logic                      dec_inv_a_s;
    logic                      dec_inv_b_s;
    logic                      dec_cin_s;
    logic                      dec_sign_s;
    logic                      dec_illegal_s;

    // Operand B selection
    logic [OPERAND_WIDTH-1:0]  op_b_s;

    // Stage register contents
    logic                      valid_r;
    logic [OPERAND_WIDTH-1:0]  in_a_r;
    logic [OPERAND_WIDTH-1:0]  in_b_r;
    logic [NUM_OPERATIONS-1:0] oper_r;
    logic                      inv_a_r;
    logic                      inv_b_r;
    logic                      cin_r;
    logic                      sign_r;
    logic [REG_ADDR_W-1:0]     dest_r;
    logic                      wr_en_r;
    logic                      illegal_r;

    // Next-state values for the stage register
    logic                      valid_s;
    logic [OPERAND_WIDTH-1:0]  in_a_s;
    logic [OPERAND_WIDTH-1:0]  in_b_s;
    logic [NUM_OPERATIONS-1:0] oper_s;
    logic                      inv_a_s;
    logic                      inv_b_s;
    logic                      cin_s;
    logic                      sign_s;
    logic [REG_ADDR_W-1:0]     dest_s;
    logic                      wr_en_s;
    logic                      illegal_s;

    alu_issue_reg_ctrl_dec u_ctrl_dec (
        .alu_op  (alu_op),
        .oper    (dec_oper_s),
        .inv_a   (dec_inv_a_s),
        .inv_b   (dec_inv_b_s),
        .cin     (dec_cin_s),
        .sign    (dec_sign_s),
        .illegal (dec_illegal_s)
    );

    // Operand B mux: immediate or register; shift amounts pass through unmasked.
    always_comb begin
        op_b_s = rf_b;
        if (use_imm) begin
            op_b_s = imm;
        end else begin
            op_b_s = rf_b;
        end
    end

    // Next-state selection: flush or an invalid slot loads a bubble, stall holds.
    always_comb begin
        valid_s   = valid_r;
        in_a_s    = in_a_r;
        in_b_s    = in_b_r;
        oper_s    = oper_r;
        inv_a_s   = inv_a_r;
        inv_b_s   = inv_b_r;
        cin_s     = cin_r;
        sign_s    = sign_r;
        dest_s    = dest_r;
        wr_en_s   = wr_en_r;
        illegal_s = illegal_r;
        if (flush || (!stall && !in_valid)) begin
            valid_s   = 1'b0;
            in_a_s    = {OPERAND_WIDTH{1'b0}};
            in_b_s    = {OPERAND_WIDTH{1'b0}};
            oper_s    = {NUM_OPERATIONS{1'b0}};
            inv_a_s   = 1'b0;
            inv_b_s   = 1'b0;
            cin_s     = 1'b0;
            sign_s    = 1'b0;
            dest_s    = {REG_ADDR_W{1'b0}};
            wr_en_s   = 1'b0;
            illegal_s = 1'b0;
        end else if (stall) begin
            valid_s   = valid_r;
            in_a_s    = in_a_r;
            in_b_s    = in_b_r;
            oper_s    = oper_r;
            inv_a_s   = inv_a_r;
            inv_b_s   = inv_b_r;
            cin_s     = cin_r;
            sign_s    = sign_r;
            dest_s    = dest_r;
            wr_en_s   = wr_en_r;
            illegal_s = illegal_r;
        end else begin
            valid_s   = 1'b1;
            in_a_s    = rf_a;
            in_b_s    = op_b_s;
            oper_s    = NUM_OPERATIONS'(dec_oper_s);
            inv_a_s   = dec_inv_a_s;
            inv_b_s   = dec_inv_b_s;
            cin_s     = dec_cin_s;
            sign_s    = dec_sign_s;
            dest_s    = dest_in;
            // an illegal instruction must never write back
            wr_en_s   = wr_en_in & ~dec_illegal_s;
            illegal_s = dec_illegal_s;
        end
    end

    // Stage register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            in_a_r    <= {OPERAND_WIDTH{1'b0}};
            in_b_r    <= {OPERAND_WIDTH{1'b0}};
            oper_r    <= {NUM_OPERATIONS{1'b0}};
            inv_a_r   <= 1'b0;
            inv_b_r   <= 1'b0;
            cin_r     <= 1'b0;
            sign_r    <= 1'b0;
            dest_r    <= {REG_ADDR_W{1'b0}};
            wr_en_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            valid_r   <= valid_s;
            in_a_r    <= in_a_s;
            in_b_r    <= in_b_s;
            oper_r    <= oper_s;
            inv_a_r   <= inv_a_s;
            inv_b_r   <= inv_b_s;
            cin_r     <= cin_s;
            sign_r    <= sign_s;
            dest_r    <= dest_s;
            wr_en_r   <= wr_en_s;
            illegal_r <= illegal_s;
        end
    end

    assign out_valid  = valid_r;
    assign InA        = in_a_r;
    assign InB        = in_b_r;
    assign Oper       = oper_r;
    assign invA       = inv_a_r;
    assign invB       = inv_b_r;
    assign Cin        = cin_r;
    assign sign       = sign_r;
    assign dest_out   = dest_r;
    assign wr_en_out  = wr_en_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_alu_issue_reg.sv
// Scoreboard bench for alu_issue_reg: the stimulus process pushes the expected
// stage contents for every edge, a monitor pops and compares after each edge.
module tb_alu_issue_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  dest_in;
    logic        wr_en_in;
    logic        out_valid;
    logic [15:0] InA;
    logic [15:0] InB;
    logic [2:0]  Oper;
    logic        invA;
    logic        invB;
    logic        Cin;
    logic        sign;
    logic [2:0]  dest_out;
    logic        wr_en_out;
    logic        illegal_op;

    typedef struct packed {
        logic        valid;
        logic [15:0] ina;
        logic [15:0] inb;
        logic [2:0]  oper;
        logic        inva;
        logic        invb;
        logic        cin;
        logic        sgn;
        logic [2:0]  dest;
        logic        wr;
        logic        ill;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    obs_t  model_r;
    int    total;
    int    bad;

    alu_issue_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .alu_op     (alu_op),
        .rf_a       (rf_a),
        .rf_b       (rf_b),
        .imm        (imm),
        .use_imm    (use_imm),
        .dest_in    (dest_in),
        .wr_en_in   (wr_en_in),
        .out_valid  (out_valid),
        .InA        (InA),
        .InB        (InB),
        .Oper       (Oper),
        .invA       (invA),
        .invB       (invB),
        .Cin        (Cin),
        .sign       (sign),
        .dest_out   (dest_out),
        .wr_en_out  (wr_en_out),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-entered opcode table {Oper,invA,invB,Cin,sign}.
    function automatic logic [6:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'd0:    return 7'b100_0001;
            4'd1:    return 7'b100_1011;
            4'd2:    return 7'b110_0000;
            4'd3:    return 7'b111_0100;
            4'd4:    return 7'b000_0000;
            4'd5:    return 7'b001_0000;
            4'd6:    return 7'b010_0000;
            4'd7:    return 7'b011_0000;
            4'd8:    return 7'b101_0000;
            4'd9:    return 7'b100_0000;
            default: return 7'b100_0001;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the stage contents expected after the edge.
    task automatic step(input string nm, input logic r, input logic s, input logic f,
                        input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] im, input logic ui,
                        input logic [2:0] d, input logic w);
        obs_t       nx;
        logic [6:0] c;
        rst = r; stall = s; flush = f; in_valid = v; alu_op = op;
        rf_a = a; rf_b = b; imm = im; use_imm = ui; dest_in = d; wr_en_in = w;
        if (r || f || (!s && !v)) begin
            nx = '0;
        end else if (s) begin
            nx = model_r;
        end else begin
            c        = ref_ctrl(op);
            nx.valid = 1'b1;
            nx.ina   = a;
            nx.inb   = ui ? im : b;
            nx.oper  = c[6:4];
            nx.inva  = c[3];
            nx.invb  = c[2];
            nx.cin   = c[1];
            nx.sgn   = c[0];
            nx.dest  = d;
            nx.ill   = (op >= 4'd10);
            nx.wr    = w & ~nx.ill;
        end
        model_r = nx;
        exp_q.push_back(nx);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the stage outputs after every edge that has a queued expectation.
    initial begin
        obs_t  e;
        obs_t  g;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                g = {out_valid, InA, InB, Oper, invA, invB, Cin, sign, dest_out, wr_en_out, illegal_op};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL %s: got v=%b A=%h B=%h op=%b iA=%b iB=%b c=%b s=%b d=%0d w=%b il=%b, want v=%b A=%h B=%h op=%b iA=%b iB=%b c=%b s=%b d=%0d w=%b il=%b",
                        n, g.valid, g.ina, g.inb, g.oper, g.inva, g.invb, g.cin, g.sgn, g.dest, g.wr, g.ill,
                        e.valid, e.ina, e.inb, e.oper, e.inva, e.invb, e.cin, e.sgn, e.dest, e.wr, e.ill);
                end
            end
        end
    end

    initial begin
        logic [15:0] alu_res;
        int          guard;
        total = 0; bad = 0; model_r = '0;

        // reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 3'd1, 1'b1);

        // ADD and SUB with immediate
        step("add",    1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h1234, 16'h0001, 16'h0000, 1'b0, 3'd3, 1'b1);
        step("sub_imm",1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0005, 16'h7777, 16'h0003, 1'b1, 3'd4, 1'b1);
        // B - A as alu_hier would form it: ~InA + InB + Cin
        alu_res = (invA ? ~InA : InA) + (invB ? ~InB : InB) + {15'd0, Cin};
        total++;
        if (alu_res !== 16'hFFFE) begin
            bad++;
            $display("FAIL sub_result: got %h want FFFE", alu_res);
        end

        // remaining legal opcodes
        step("xor",    1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 3'd5, 1'b1);
        step("rol",    1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'h8001, 16'h0000, 16'h0013, 1'b1, 3'd6, 1'b0);
        step("sll",    1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0001, 16'h00FF, 16'h0000, 1'b0, 3'd7, 1'b1);
        step("ror",    1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 16'h1357, 16'h0004, 16'h0000, 1'b0, 3'd2, 1'b1);
        step("or",     1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 16'hA000, 16'h000B, 16'h0000, 1'b0, 3'd1, 1'b1);
        step("addu",   1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 1'b1);

        // stall: load ANDN then freeze for three cycles with changing inputs
        step("andn",   1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h00F0, 16'h0F0F, 16'h0000, 1'b0, 3'd3, 1'b1);
        step("stall1", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'h1111, 16'h2222, 16'h3333, 1'b1, 3'd5, 1'b0);
        step("stall2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h4444, 16'h5555, 16'h6666, 1'b0, 3'd6, 1'b1);
        step("stall3", 1'b0, 1'b1, 1'b0, 1'b1, 4'd12,16'h7777, 16'h8888, 16'h9999, 1'b0, 3'd7, 1'b1);
        step("unstall",1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'hBEEF, 16'h0003, 16'h0000, 1'b0, 3'd2, 1'b1);

        // flush with stall and valid inputs, then flush alone, then empty slot
        step("flush_st",1'b0,1'b1, 1'b1, 1'b1, 4'd0, 16'hCAFE, 16'hF00D, 16'h0000, 1'b0, 3'd4, 1'b1);
        step("reload", 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 16'h0F00, 16'h00F0, 16'h0000, 1'b0, 3'd1, 1'b1);
        step("flush",  1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 16'h0F00, 16'h00F0, 16'h0000, 1'b0, 3'd1, 1'b1);
        step("reload2",1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h1234, 16'h4321, 16'h0000, 1'b0, 3'd6, 1'b1);
        step("bubble", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h1234, 16'h4321, 16'h0000, 1'b0, 3'd6, 1'b1);

        // illegal opcodes: boundary 10, the 0xC case and 15
        step("ill_c",  1'b0, 1'b0, 1'b0, 1'b1, 4'd12,16'h0101, 16'h0202, 16'h0000, 1'b0, 3'd3, 1'b1);
        step("ill_a",  1'b0, 1'b0, 1'b0, 1'b1, 4'd10,16'h0303, 16'h0404, 16'h0505, 1'b1, 3'd5, 1'b1);
        step("ill_f",  1'b0, 1'b0, 1'b0, 1'b1, 4'd15,16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 3'd7, 1'b0);

        // reset mid-stream while stalled with a valid stage
        step("pre_rst",1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0042, 16'h0084, 16'h0000, 1'b0, 3'd2, 1'b1);
        step("hold",   1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0);
        step("rst_st", 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h9999, 16'h1111, 16'h0000, 1'b0, 3'd4, 1'b1);
        step("post_rst",1'b0,1'b0, 1'b0, 1'b1, 4'd6, 16'h5A5A, 16'h0008, 16'h0000, 1'b0, 3'd4, 1'b1);
        step("idle",   1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
